// File: rtl/disp_src_sched.sv
// Round-robin scheduler sharing one seven-segment display driver between four 32-bit sources.
// Each granted source is shown for HOLD cycles. A GAP-cycle blank follows every slot.
module disp_src_sched #(
  parameter int HOLD = 200_000_000,
  parameter int GAP  = 10_000_000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   req,
  input  logic         lock,
  input  logic [127:0] data,
  output logic [3:0]   gnt,
  output logic [31:0]  x,
  output logic         e,
  output logic [3:0]   done
);

  // state   | meaning
  // ST_IDLE | nothing displayed, waiting for any request
  // ST_SHOW | source cur on the display for its slot
  // ST_GAP  | blank interval between slots
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  localparam logic [31:0] HOLD_TC = 32'(HOLD - 1);
  localparam logic [31:0] GAP_TC  = 32'(GAP - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  cur;
  logic [31:0] cnt;
  logic [1:0]  arb_idx;
  logic [1:0]  probe;

  // Descending scan so the candidate closest to ptr is written last and wins.
  always_comb begin
    arb_idx = ptr;
    probe   = ptr;
    for (int k = 3; k >= 0; k--) begin
      probe = ptr + 2'(k);
      if (req[probe]) arb_idx = probe;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      e     <= 1'b0;
      x     <= '0;
      done  <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_SHOW;
            cur   <= arb_idx;
            cnt   <= '0;
            gnt   <= 4'b0001 << arb_idx;
            e     <= 1'b1;
            x     <= data[{arb_idx, 5'd0} +: 32];
          end
        end
        ST_SHOW: begin
          x <= data[{cur, 5'd0} +: 32];
          // Withdrawal ends the slot regardless of lock and earns no done pulse.
          if (!req[cur]) begin
            state <= ST_GAP;
            cnt   <= '0;
            ptr   <= cur + 2'd1;
            gnt   <= '0;
            e     <= 1'b0;
          end else if (cnt == HOLD_TC) begin
            if (!lock) begin
              state <= ST_GAP;
              cnt   <= '0;
              ptr   <= cur + 2'd1;
              gnt   <= '0;
              e     <= 1'b0;
              done  <= 4'b0001 << cur;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_TC) begin
            if (|req) begin
              state <= ST_SHOW;
              cur   <= arb_idx;
              cnt   <= '0;
              gnt   <= 4'b0001 << arb_idx;
              e     <= 1'b1;
              x     <= data[{arb_idx, 5'd0} +: 32];
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/disp_src_sched.md
# disp_src_sched

Round-robin scheduler that shares the single 4-digit seven-segment display driver between four 32-bit value sources: operand A, operand B, product/quotient and remainder of the mult/div unit. It sits between the mult/div datapath and the display driver. It drives the driver's `x` value and `e` enable, and grants each requesting source a fixed display slot. Between slots it inserts a blanking gap so the source change is visible to the user.

## Interface
- `HOLD`, default 2*10**8: cycles each granted source is shown (2 s at 100 MHz). Must be ≥ 1.
- `GAP`, default 10**7: blank cycles between slots (0.1 s). Must be ≥ 1.
- `CLK` in 1: board clock, 100 MHz.
- `RST` in 1: reset, synchronous, active-high.
- `req` in 4: `req[i]` high means source i wants display time. Level-sensitive.
- `lock` in 1: freezes the current slot while high, so the user can hold a value on screen.
- `data` in 128: source i value is `data[32*i+31:32*i]`.
- `gnt` out 4: one-hot grant, all zero when no slot is active.
- `x` out 32: value to the display driver.
- `e` out 1: display driver enable. High only during a slot.
- `done` out 4: one-cycle pulse, `done[i]` marks the end of a completed slot of source i.

## Operation
- States: IDLE, SHOW, GAP.
- State variables:
  - `ptr` (2 bits): highest-priority index.
  - `cur` (2 bits): granted index.
  - `cnt`: 32-bit cycle counter.
- Arbitration picks the first index i with `req[i]` high, searching `ptr`, `ptr+1`, … mod 4.
- IDLE
  - Outputs: `e`=0, `gnt`=0, `x` holds its last value.
  - If any `req` is high: `cur` ← arbitrated index, `cnt` ← 0, go to SHOW.
- SHOW
  - Outputs: `gnt`=one-hot(`cur`), `e`=1.
  - `x` ← data slice `cur` every cycle, so live updates of the source are tracked.
  - If `req[cur]` drops (withdrawal): go to GAP, `cnt` ← 0, no `done` pulse, `ptr` ← `cur`+1.
  - Else if `cnt` == HOLD-1 and `lock`=0 (slot end): go to GAP, `cnt` ← 0, `done[cur]` pulses, `ptr` ← `cur`+1 mod 4.
  - Else if `cnt` == HOLD-1 and `lock`=1: stay in SHOW, `cnt` saturates at HOLD-1. The slot ends on the first cycle `lock` is low.
  - Otherwise `cnt` ← `cnt`+1.
  - Withdrawal has priority over `lock`.
- GAP
  - Outputs: `e`=0, `gnt`=0, `x` holds its value.
  - When `cnt` == GAP-1: if any `req` is high, arbitrate and go directly to SHOW, otherwise go to IDLE.
  - Otherwise `cnt` ← `cnt`+1.
- `req` changes during GAP are only sampled at the GAP exit decision.
- A sole continuous requester is re-granted after every gap.
- `data` bits of non-granted sources never reach `x`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `gnt`=0, `e`=0, `x`=0, `done`=0, `ptr`=0, `cur`=0, `cnt`=0.
- `RST` mid-slot returns to these values on the next edge and suppresses any pending `done`.
- IDLE→SHOW latency: `req` high in cycle t gives `gnt`/`e` high in cycle t+1 and valid `x` in t+1.
- `x` lags `data` by one cycle during SHOW.
- Slot length without lock or withdrawal is exactly HOLD cycles of `gnt`≠0.
- `done[cur]` is high in the first GAP cycle only.
- A withdrawal observed in cycle t gives `gnt`=0 in t+1.
- Gap between consecutive grants is exactly GAP cycles of `gnt`=0, `e`=0.
- `gnt` is never multi-hot. `e` equals OR of `gnt` in every cycle.

## Test plan
Use HOLD=4, GAP=2 for all scenarios.
- Reset, then `req`=0000 for 10 cycles → `gnt`=0, `e`=0, `x`=0, `done`=0 throughout.
- `req`=1111 held; `data` slices 0x00000000, 0x11111111, 0x22222222, 0x33333333 → grants 0,1,2,3,0 in order.
  - Each grant lasts 4 cycles, separated by 2 blank cycles.
  - `done` pulses 0001, 0010, 0100, 1000.
  - `x` matches the granted slice.
- `req`=0100 only, `data` slice 2 incremented every cycle → source 2 re-granted after every 2-cycle gap.
  - `x` equals the previous cycle's slice 2 during SHOW.
- Source 1 granted, `lock`=1 from the second SHOW cycle for 10 cycles → `gnt`=0010 held for 12 cycles total.
  - `done[1]` pulses one cycle after `lock` falls.
- Source 3 granted, `req[3]` dropped in the second SHOW cycle with `lock`=1 → `gnt`=0 the next cycle, no `done` pulse.
  - After 2 gap cycles source 0 is granted if `req[0]` is high.
- `RST` asserted in the third SHOW cycle of source 2 → all outputs 0 the next cycle, no `done` pulse.
  - After release with `req`=1111, source 0 is granted first.
